// File: rtl/pet_event_scheduler.sv
// Pet event scheduler: debounced feed/sleep/play buttons,
// round-robin valid/ready event offer and a scalable time tick.
module pet_event_scheduler #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_BASE  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       luz,
  input  logic       test,
  input  logic [1:0] time_control,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       tick,
  output logic       sleep_rej,
  output logic       evt_drop
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  localparam logic [7:0]  DEB_W  = 8'(DEB_CYCLES);
  localparam logic [15:0] TBASE  = 16'(TICK_BASE);

  function automatic logic [1:0] f_wrap(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  logic [2:0] w_btn;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_deb;
  logic [2:0] r_deb_q;
  logic [7:0] r_dcnt [3];
  logic [2:0] w_rise;

  assign w_btn  = {C, B, A};
  assign w_rise = r_deb & ~r_deb_q;

  // debounce: count only while the synced level differs from the accepted one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int i = 0; i < 3; i++) r_dcnt[i] <= '0;
    end else begin
      r_s1    <= w_btn;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DEB_W) begin
          r_deb[i]  <= r_s2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 8'd1;
        end
      end
    end
  end

  state_t     r_state;
  state_t     w_state_n;
  logic [2:0] r_pend;
  logic [2:0] w_pend_n;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_n;
  logic [1:0] r_code;
  logic [1:0] w_code_n;
  logic       r_rej;
  logic       w_rej_n;
  logic       r_drop;
  logic       w_drop_n;
  logic [2:0] w_clr;
  logic       w_load_ok;
  logic       w_found;
  logic [1:0] w_idx;
  logic [1:0] w_cand;

  always_comb begin
    w_state_n = r_state;
    w_code_n  = r_code;
    w_ptr_n   = r_ptr;
    w_clr     = '0;
    w_rej_n   = 1'b0;
    w_found   = 1'b0;
    w_idx     = 2'd0;
    w_cand    = 2'd0;
    w_load_ok = (r_state == IDLE) || evt_ready;
    for (int k = 0; k < 3; k++) begin
      w_cand = f_wrap({1'b0, r_ptr} + 3'(k));
      if (!w_found && r_pend[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    if (w_load_ok) begin
      if (r_state == OFFER) w_state_n = IDLE;
      if (w_found) begin
        w_clr[w_idx] = 1'b1;
        w_ptr_n      = f_wrap({1'b0, w_idx} + 3'd1);
        if (w_idx == 2'd1 && luz) begin
          w_rej_n = 1'b1;
        end else begin
          w_state_n = OFFER;
          w_code_n  = w_idx + 2'd1;
        end
      end
    end
    // a grant in the same cycle as a new press wins silently
    for (int i = 0; i < 3; i++)
      w_pend_n[i] = w_clr[i] ? 1'b0 : (r_pend[i] | w_rise[i]);
    w_drop_n = |(w_rise & r_pend & ~w_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_ptr   <= 2'd0;
      r_code  <= 2'd0;
      r_rej   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_ptr   <= w_ptr_n;
      r_code  <= w_code_n;
      r_rej   <= w_rej_n;
      r_drop  <= w_drop_n;
    end
  end

  logic [15:0] w_per;
  logic [15:0] w_last;
  logic [15:0] r_tcnt;
  logic [1:0]  r_tc;
  logic        r_test;
  logic        r_tick;

  assign w_per  = TBASE >> {time_control, 1'b0};
  assign w_last = (test || w_per <= 16'd1) ? 16'd0 : w_per - 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt <= '0;
      r_tc   <= 2'd0;
      r_test <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tc   <= time_control;
      r_test <= test;
      if (time_control != r_tc || test != r_test) begin
        r_tcnt <= '0;
        r_tick <= 1'b0;
      end else if (r_tcnt >= w_last) begin
        r_tcnt <= '0;
        r_tick <= 1'b1;
      end else begin
        r_tcnt <= r_tcnt + 16'd1;
        r_tick <= 1'b0;
      end
    end
  end

  assign evt_valid = (r_state == OFFER);
  assign evt_code  = evt_valid ? r_code : 2'b00;
  assign tick      = r_tick;
  assign sleep_rej = r_rej;
  assign evt_drop  = r_drop;

endmodule
